ubcse_share_arb: RTL and testbench
==================================

# ubcse_share_arb

Round-robin arbiter and sequencer that shares one 8-bit carry-select adder core (`UBPriCSlA_7_0`, with carry-in) among NREQ requesters. It supports single-byte adds and locked multi-byte (multi-precision) adds, where the carry is chained across consecutive beats from the same requester. The block sits between the requesting datapath engines and the adder. It returns one registered result per accepted beat.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_x  in  8*NREQ  operand X; requester i uses bits [8i+7:8i].
- req_y  in  8*NREQ  operand Y, same packing.
- req_last  in  NREQ  beat is the final (or only) byte of a transaction.
- rsp_valid  out  1  result valid, single-cycle pulse per accepted beat.
- rsp_id  out  IDW  requester that owns the result.
- rsp_sum  out  9  {carry_out, sum[7:0]} of the beat.
- rsp_last  out  1  copy of req_last of the beat.
- busy  out  1  high while a multi-byte transaction holds the lock.

## Operation
- Decided: one clock; reset is synchronous and active-high.
- States:
  - ARB: grant goes to the first requester with req_valid=1, searching from ptr upward and wrapping modulo NREQ.
  - LOCK: only the owner can be granted.
- req_ready[i] = 1 iff i is the granted requester and req_valid[i]=1. It is combinational from state, ptr, owner and req_valid. A beat is accepted when req_valid[i] & req_ready[i].
- Carry-in to the adder:
  - 0 in ARB.
  - carry register in LOCK.
- On every accepted beat, carry register <= adder S[8].
- State transitions:
  - ARB, accepted beat with last=0 -> LOCK, owner <= i.
  - ARB, accepted beat with last=1 -> stay in ARB, ptr <= (i+1) mod NREQ.
  - LOCK, accepted beat with last=1 -> ARB, ptr <= (owner+1) mod NREQ, carry <= 0.
  - LOCK, accepted beat with last=0 -> stay in LOCK.
- Owner deasserts req_valid while in LOCK: the block stays in LOCK indefinitely and other requesters are starved. There is no timeout.
- The response port has no backpressure; the consumer must always accept.
- busy = (state == LOCK).

## Timing
- Latency: a beat accepted at cycle t produces rsp_valid=1 at cycle t+1 with registered rsp_sum, rsp_id and rsp_last.
- Throughput: one beat per cycle, including back-to-back beats of a locked transaction. The chained carry comes from the register updated at the previous edge.
- The grant pointer advances only on transaction completion, never on non-last beats.
- Reset values: state=ARB, ptr=0, owner=0, carry=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_last=0, busy=0.
- Reset asserted mid-LOCK aborts the transaction:
  - no response is issued for a beat presented in the reset cycle;
  - req_ready is 0 during reset.
- Simultaneous requests in ARB: lowest index at or above ptr wins (wrap-around). Example: ptr=3 with requests {0,2} grants 0.
- No combinational path from req_* to rsp_*. The adder path is registered at the output only.

## Structure
- Shared package ubcse_pkg:
  - localparam ADD_W=8;
  - state enum {ST_ARB, ST_LOCK};
  - function rr_pick(req, ptr) returning a one-hot grant.
- One sub-module instance: `UBPriCSlA_7_0` (S[8:0], X, Y, Cin), driven from operands muxed by grant.
- Everything else is flat in ubcse_share_arb: grant logic, FSM, carry and output registers.

## Test plan
- Single add: req_valid=0001, x0=0xFF, y0=0x01, last=1 -> ready=0001 in the same cycle. Next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x100, rsp_last=1, carry register back to 0.
- Multi-byte 16-bit: req1 beats (0xFF,0x01,last=0) then (0x00,0x00,last=1) -> responses 0x100 then 0x001, busy=1 between the beats. Requester 2 stays valid and gets no ready until after the last beat.
- Round robin, all four valid continuously with last=1 -> grants in order 0,1,2,3,0,… with one rsp per cycle.
- Wrap priority: ptr=3 (after a req2 grant), req_valid=0101 -> grant 0, then 2.
- Owner stall: req3 in LOCK drops valid for 5 cycles while req0 is valid -> req_ready=0 throughout. Carry is preserved, and the next req3 beat (0x00,0x00,last=1) returns 0x001.
- Reset mid-LOCK: assert rst for one cycle after the first beat -> all outputs zero, state ARB, ptr=0. A fresh req2 single add 0x80+0x80 returns 0x100 with no stale carry.

Source files
------------

// File: rtl/ubcse_pkg.sv
// ubcse_pkg: shared constants, FSM states and round-robin pick for the adder arbiter
package ubcse_pkg;
  localparam int ADD_W = 8;
  typedef enum logic {ST_ARB, ST_LOCK} state_e;
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [7:0] g;
    logic [2:0] idx;
    g = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && req[idx]) g = 8'(1) << idx;
    end
    return g;
  endfunction
endpackage

// File: rtl/UBPriCSlA_7_0.sv
// UBPriCSlA_7_0: 8-bit carry-select adder with carry-in, S = {cout, sum}
module UBPriCSlA_7_0 (
  output logic [8:0] S,
  input  logic [7:0] X,
  input  logic [7:0] Y,
  input  logic       Cin
);
  logic [4:0] lo, hi0, hi1;
  assign lo  = {1'b0, X[3:0]} + {1'b0, Y[3:0]} + {4'b0, Cin};
  assign hi0 = {1'b0, X[7:4]} + {1'b0, Y[7:4]};
  assign hi1 = hi0 + 5'd1;
  assign S   = {lo[4] ? hi1 : hi0, lo[3:0]};
endmodule

// File: rtl/ubcse_share_arb.sv
// ubcse_share_arb: round-robin sharing of one 8-bit adder with locked multi-byte carry chaining
module ubcse_share_arb
  import ubcse_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_x,
  input  logic [8*NREQ-1:0]    req_y,
  input  logic [NREQ-1:0]      req_last,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [ADD_W:0]       rsp_sum,
  output logic                 rsp_last,
  output logic                 busy
);
  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d, owner_q, owner_d, gidx, nidx;
  logic              carry_q, carry_d, cin, last_s, acc;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        pick;
  logic [ADD_W-1:0]  xs, ys;
  logic [ADD_W:0]    s;
  logic              rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [ADD_W:0]    rsp_sum_q, rsp_sum_d;

  UBPriCSlA_7_0 u_add (.S(s), .X(xs), .Y(ys), .Cin(cin));

  // grant selection and operand mux for the granted requester
  always_comb begin
    pick = rr_pick(8'(req_valid), 3'(ptr_q), NREQ);
    gnt  = state_q == ST_LOCK ? req_valid & (NREQ'(1) << owner_q) : pick[NREQ-1:0];
    gidx = '0;
    xs = '0;
    ys = '0;
    last_s = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        gidx = IDW'(i);
        xs = req_x[8*i +: 8];
        ys = req_y[8*i +: 8];
        last_s = req_last[i];
      end
    req_ready = rst ? '0 : gnt;
    acc = |gnt & !rst;
    cin = state_q == ST_LOCK ? carry_q : 1'b0;
  end

  // lock FSM, pointer, owner, chained carry and registered response
  always_comb begin
    nidx = (state_q == ST_LOCK ? owner_q : gidx);
    nidx = nidx == IDW'(NREQ - 1) ? '0 : nidx + IDW'(1);
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    carry_d = carry_q;
    if (acc) begin
      carry_d = last_s ? 1'b0 : s[ADD_W];
      if (last_s) begin
        state_d = ST_ARB;
        ptr_d = nidx;
      end else if (state_q == ST_ARB) begin
        state_d = ST_LOCK;
        owner_d = gidx;
      end
    end
    rsp_valid_d = acc;
    rsp_id_d = acc ? gidx : rsp_id_q;
    rsp_sum_d = acc ? s : rsp_sum_q;
    rsp_last_d = acc ? last_s : rsp_last_q;
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      ptr_q <= '0;
      owner_q <= '0;
      carry_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_sum_q <= '0;
      rsp_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      carry_q <= carry_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_last_q <= rsp_last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_sum = rsp_sum_q;
  assign rsp_last = rsp_last_q;
  assign busy = state_q == ST_LOCK;
endmodule

// File: tb/tb_ubcse_share_arb.sv
// tb_ubcse_share_arb: directed checks of arbitration, locking, carry chaining and reset
module tb_ubcse_share_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_last;
  logic [31:0] req_x, req_y;
  logic        rsp_valid, rsp_last, busy;
  logic [1:0]  rsp_id;
  logic [8:0]  rsp_sum;
  int tests = 0;
  int fails = 0;

  ubcse_share_arb #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_last(req_last), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y, input logic l);
    req_x[8*i +: 8] = x;
    req_y[8*i +: 8] = y;
    req_last[i] = l;
    #1;
  endtask

  task automatic chk_ready(input string n, input logic [3:0] e);
    tests++;
    if (req_ready !== e) begin
      fails++;
      $display("FAIL %s ready got %b exp %b", n, req_ready, e);
    end
  endtask

  task automatic chk_rsp(input string n, input logic v, input logic [1:0] id, input logic [8:0] sm, input logic l, input logic b);
    tests++;
    if (rsp_valid !== v || (v && (rsp_id !== id || rsp_sum !== sm || rsp_last !== l)) || busy !== b) begin
      fails++;
      $display("FAIL %s got v=%b id=%0d sum=%h last=%b busy=%b exp v=%b id=%0d sum=%h last=%b busy=%b",
               n, rsp_valid, rsp_id, rsp_sum, rsp_last, busy, v, id, sm, l, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_x = '0;
    req_y = '0;
    req_last = 4'b1111;
    tick();
    tick();
    chk_ready("reset_ready", 4'b0000);
    tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 9'h0 || rsp_last !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got v=%b id=%0d sum=%h last=%b busy=%b exp all zero", rsp_valid, rsp_id, rsp_sum, rsp_last, busy);
    end
    req_valid = 4'b0000;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    set_op(0, 8'hFF, 8'h01, 1'b1);
    chk_ready("single_ready", 4'b0001);
    tick();
    req_valid = 4'b0000;
    chk_rsp("single_rsp", 1'b1, 2'd0, 9'h100, 1'b1, 1'b0);
    tick();
    chk_rsp("single_idle", 1'b0, 2'd0, 9'h0, 1'b0, 1'b0);
  endtask

  task automatic test_multi();
    req_valid = 4'b0110;
    set_op(1, 8'hFF, 8'h01, 1'b0);
    set_op(2, 8'h10, 8'h20, 1'b1);
    chk_ready("multi_b0_ready", 4'b0010);
    tick();
    chk_rsp("multi_b0_rsp", 1'b1, 2'd1, 9'h100, 1'b0, 1'b1);
    set_op(1, 8'h00, 8'h00, 1'b1);
    chk_ready("multi_b1_ready", 4'b0010);
    tick();
    chk_rsp("multi_b1_rsp", 1'b1, 2'd1, 9'h001, 1'b1, 1'b0);
    req_valid = 4'b0100;
    #1;
    chk_ready("multi_req2_ready", 4'b0100);
    tick();
    req_valid = 4'b0000;
    chk_rsp("multi_req2_rsp", 1'b1, 2'd2, 9'h030, 1'b1, 1'b0);
  endtask

  task automatic test_round_robin();
    int order[6] = '{3, 0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) set_op(i, 8'(16 * i), 8'(i), 1'b1);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk_ready($sformatf("rr_ready_%0d", k), 4'(1 << order[k]));
      tick();
      chk_rsp($sformatf("rr_rsp_%0d", k), 1'b1, 2'(order[k]), 9'(17 * order[k]), 1'b1, 1'b0);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    req_valid = 4'b0100;
    #1;
    chk_ready("wrap_setup_ready", 4'b0100);
    tick();
    req_valid = 4'b0101;
    #1;
    chk_ready("wrap_first_ready", 4'b0001);
    tick();
    chk_rsp("wrap_first_rsp", 1'b1, 2'd0, 9'h000, 1'b1, 1'b0);
    chk_ready("wrap_second_ready", 4'b0100);
    tick();
    req_valid = 4'b0000;
    chk_rsp("wrap_second_rsp", 1'b1, 2'd2, 9'h022, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    req_valid = 4'b1000;
    set_op(3, 8'hFF, 8'h01, 1'b0);
    set_op(0, 8'h01, 8'h01, 1'b1);
    chk_ready("stall_b0_ready", 4'b1000);
    tick();
    chk_rsp("stall_b0_rsp", 1'b1, 2'd3, 9'h100, 1'b0, 1'b1);
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_ready($sformatf("stall_ready_%0d", k), 4'b0000);
      tick();
      chk_rsp($sformatf("stall_rsp_%0d", k), 1'b0, 2'd0, 9'h0, 1'b0, 1'b1);
    end
    req_valid = 4'b1001;
    set_op(3, 8'h00, 8'h00, 1'b1);
    chk_ready("stall_b1_ready", 4'b1000);
    tick();
    req_valid = 4'b0000;
    chk_rsp("stall_b1_rsp", 1'b1, 2'd3, 9'h001, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset_lock();
    req_valid = 4'b0100;
    set_op(2, 8'hFF, 8'h01, 1'b0);
    tick();
    chk_rsp("rlock_b0_rsp", 1'b1, 2'd2, 9'h100, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk_ready("rlock_rst_ready", 4'b0000);
    tick();
    rst = 1'b0;
    chk_rsp("rlock_after_rst", 1'b0, 2'd0, 9'h0, 1'b0, 1'b0);
    tests++;
    if (rsp_sum !== 9'h0 || rsp_id !== 2'd0) begin
      fails++;
      $display("FAIL rlock_regs got id=%0d sum=%h exp 0 000", rsp_id, rsp_sum);
    end
    req_valid = 4'b1100;
    set_op(2, 8'h80, 8'h80, 1'b1);
    set_op(3, 8'h01, 8'h02, 1'b1);
    chk_ready("rlock_fresh_ready", 4'b0100);
    tick();
    req_valid = 4'b0000;
    chk_rsp("rlock_fresh_rsp", 1'b1, 2'd2, 9'h100, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_round_robin();
    test_wrap();
    test_stall();
    test_reset_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
